// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle between the PC sequencer and the decode/branch-resolution logic.
// The master drives the control inputs. The slave (the sequencer) drives the PC and status outputs.
interface pc_sequencer_if #(
    parameter int PC_WIDTH = 32
);
    logic                stall;
    logic [31:0]         instruction;
    logic [1:0]          pc_sel;
    logic                branch_taken;
    logic [PC_WIDTH-1:0] jr_target;
    logic                exception;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] epc;
    logic                misalign_err;
    logic                slot_violation;
    logic                in_delay_slot;

    modport master (
        output stall, instruction, pc_sel, branch_taken, jr_target, exception,
        input  pc, pc_inc, epc, misalign_err, slot_violation, in_delay_slot
    );

    modport slave (
        input  stall, instruction, pc_sel, branch_taken, jr_target, exception,
        output pc, pc_inc, epc, misalign_err, slot_violation, in_delay_slot
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer. It handles sequential, branch, jump, register-jump and exception
// redirects, with stall, an optional delay slot and a misaligned-target trap.
module pc_sequencer #(
    parameter int                  PC_WIDTH     = 32,
    parameter int                  JUMP_FIELD   = 26,
    parameter int                  SHIFT        = 2,
    parameter int                  DELAY_SLOT   = 1,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(32'h0000_0000),
    parameter logic [PC_WIDTH-1:0] EXC_VECTOR   = PC_WIDTH'(32'h8000_0180)
) (
    input logic           clk,
    input logic           rst_n,
    pc_sequencer_if.slave bus
);
    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] SLOT = 1'b1;

    localparam logic [PC_WIDTH-1:0] INC = PC_WIDTH'(1) << SHIFT;

    logic [0:0]          state_reg;
    logic [PC_WIDTH-1:0] pc_reg;
    logic [PC_WIDTH-1:0] epc_reg;
    logic [PC_WIDTH-1:0] pending_reg;
    logic                misalign_reg;
    logic                violation_reg;

    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] branch_off;
    logic [PC_WIDTH-1:0] jump_target;
    logic [PC_WIDTH-1:0] target;
    logic                transfer;
    logic                misaligned;
    logic                unused_bits;

    assign pc_inc      = pc_reg + INC;
    assign branch_off  = {{(PC_WIDTH-16){bus.instruction[15]}}, bus.instruction[15:0]} << SHIFT;
    // The jump keeps the region bits of the next PC, not of the current one.
    assign jump_target = {pc_inc[PC_WIDTH-1:JUMP_FIELD+SHIFT],
                          bus.instruction[JUMP_FIELD-1:0], {SHIFT{1'b0}}};
    assign transfer    = (bus.pc_sel == 2'd1 && bus.branch_taken) ||
                         bus.pc_sel == 2'd2 || bus.pc_sel == 2'd3;
    assign misaligned  = (bus.pc_sel == 2'd3) && (|bus.jr_target[SHIFT-1:0]);
    assign unused_bits = &{1'b0, bus.instruction};

    always_comb begin
        target = pc_inc;
        case (bus.pc_sel)
            2'd1:    target = pc_inc + branch_off;
            2'd2:    target = jump_target;
            2'd3:    target = bus.jr_target;
            default: target = pc_inc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= RUN;
            pc_reg        <= RESET_VECTOR;
            epc_reg       <= '0;
            pending_reg   <= '0;
            misalign_reg  <= 1'b0;
            violation_reg <= 1'b0;
        end else begin
            misalign_reg  <= 1'b0;
            violation_reg <= 1'b0;
            if (bus.exception) begin
                pc_reg      <= EXC_VECTOR;
                epc_reg     <= pc_reg;
                state_reg   <= RUN;
                pending_reg <= '0;
            end else if (bus.stall) begin
                // The PC, the state and the pending target hold. Only the pulses clear.
            end else if (misaligned) begin
                pc_reg       <= EXC_VECTOR;
                epc_reg      <= pc_reg;
                misalign_reg <= 1'b1;
                state_reg    <= RUN;
            end else if (state_reg == SLOT) begin
                pc_reg        <= pending_reg;
                state_reg     <= RUN;
                violation_reg <= transfer;
            end else if (transfer && DELAY_SLOT != 0) begin
                pc_reg      <= pc_inc;
                pending_reg <= target;
                state_reg   <= SLOT;
            end else if (transfer) begin
                pc_reg <= target;
            end else begin
                pc_reg <= pc_inc;
            end
        end
    end

    assign bus.pc             = pc_reg;
    assign bus.pc_inc         = pc_inc;
    assign bus.epc            = epc_reg;
    assign bus.misalign_err   = misalign_reg;
    assign bus.slot_violation = violation_reg;
    assign bus.in_delay_slot  = (state_reg == SLOT);
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench: runs a DELAY_SLOT=0 and a DELAY_SLOT=1 sequencer side by side,
// sharing control inputs but using separate stalls so the two PCs can be re-aligned.
module tb_pc_sequencer;
    localparam logic [31:0] EXC = 32'h8000_0180;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pc_sequencer_if #(.PC_WIDTH(32)) if0 ();
    pc_sequencer_if #(.PC_WIDTH(32)) if1 ();

    pc_sequencer #(.DELAY_SLOT(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    pc_sequencer #(.DELAY_SLOT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    logic [1:0]  sel = 2'd0;
    logic        br = 1'b0;
    logic [31:0] instr = 32'h0;
    logic [31:0] jr = 32'h0;
    logic        exc = 1'b0;
    logic        st0 = 1'b0;
    logic        st1 = 1'b0;

    assign if0.pc_sel = sel;  assign if1.pc_sel = sel;
    assign if0.branch_taken = br;  assign if1.branch_taken = br;
    assign if0.instruction = instr;  assign if1.instruction = instr;
    assign if0.jr_target = jr;  assign if1.jr_target = jr;
    assign if0.exception = exc;  assign if1.exception = exc;
    assign if0.stall = st0;  assign if1.stall = st1;

    typedef struct {
        string       tag;
        logic [31:0] pc0, pc1, epc0, epc1;
        logic        ids1, mis, sv1;
    } exp_t;

    exp_t sb[$];
    int npass = 0;
    int ntotal = 0;
    logic [31:0] e_epc0 = 32'h0;
    logic [31:0] e_epc1 = 32'h0;

    task automatic chk(input string tag, input string field, input logic [31:0] obs, input logic [31:0] expv);
        ntotal++;
        assert (obs === expv) npass++;
        else $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, expv);
    endtask

    task automatic drive(input logic [1:0] s, input logic b, input logic [31:0] i,
                         input logic [31:0] j, input logic e, input logic s0, input logic s1);
        sel = s; br = b; instr = i; jr = j; exc = e; st0 = s0; st1 = s1;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] p0, input logic [31:0] p1,
                              input logic ids, input logic mis, input logic sv);
        exp_t e;
        e.tag = tag; e.pc0 = p0; e.pc1 = p1; e.epc0 = e_epc0; e.epc1 = e_epc1;
        e.ids1 = ids; e.mis = mis; e.sv1 = sv;
        sb.push_back(e);
    endtask

    task automatic check_pop();
        exp_t e;
        if (sb.size() == 0) begin
            ntotal++;
            $error("FAIL sb_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            chk(e.tag, "pc0", if0.pc, e.pc0);
            chk(e.tag, "epc0", if0.epc, e.epc0);
            chk(e.tag, "mis0", {31'b0, if0.misalign_err}, {31'b0, e.mis});
            chk(e.tag, "pc1", if1.pc, e.pc1);
            chk(e.tag, "epc1", if1.epc, e.epc1);
            chk(e.tag, "mis1", {31'b0, if1.misalign_err}, {31'b0, e.mis});
            chk(e.tag, "ids1", {31'b0, if1.in_delay_slot}, {31'b0, e.ids1});
            chk(e.tag, "sv1", {31'b0, if1.slot_violation}, {31'b0, e.sv1});
            $display("step %-10s pc0=%h pc1=%h ids1=%b", e.tag, if0.pc, if1.pc, if1.in_delay_slot);
        end
    endtask

    task automatic step(input string tag, input logic [31:0] p0, input logic [31:0] p1,
                        input logic ids, input logic mis, input logic sv);
        expect_out(tag, p0, p1, ids, mis, sv);
        @(posedge clk);
        #1;
        check_pop();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(2'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        check_pop();
        rst_n = 1'b1;

        step("run1", 32'h4, 32'h4, 0, 0, 0);
        step("run2", 32'h8, 32'h8, 0, 0, 0);
        step("run3", 32'hC, 32'hC, 0, 0, 0);

        drive(2'd3, 0, 32'h0, 32'h0040_0010, 0, 0, 0);
        step("jr_a", 32'h0040_0010, 32'h0000_0010, 1, 0, 0);
        drive(2'd0, 0, 32'h0, 32'h0, 0, 1, 0);
        step("align_a", 32'h0040_0010, 32'h0040_0010, 0, 0, 0);

        drive(2'd2, 0, 32'h0810_0040, 32'h0, 0, 0, 0);
        step("jump", 32'h0040_0100, 32'h0040_0014, 1, 0, 0);
        drive(2'd0, 0, 32'h0, 32'h0, 0, 1, 0);
        step("jump_done", 32'h0040_0100, 32'h0040_0100, 0, 0, 0);

        drive(2'd3, 0, 32'h0, 32'h100, 0, 0, 0);
        step("jr_b", 32'h100, 32'h0040_0104, 1, 0, 0);
        drive(2'd0, 0, 32'h0, 32'h0, 0, 1, 0);
        step("align_b", 32'h100, 32'h100, 0, 0, 0);

        drive(2'd1, 1, 32'h0000_FFFE, 32'h0, 0, 0, 0);
        step("branch", 32'hFC, 32'h104, 1, 0, 0);
        drive(2'd0, 0, 32'h0, 32'h0, 0, 0, 1);
        step("slot_st1", 32'h100, 32'h104, 1, 0, 0);
        step("slot_st2", 32'h104, 32'h104, 1, 0, 0);
        drive(2'd0, 0, 32'h0, 32'h0, 0, 0, 0);
        step("slot_done", 32'h108, 32'hFC, 0, 0, 0);
        drive(2'd1, 0, 32'h0000_FFFE, 32'h0, 0, 0, 0);
        step("not_taken", 32'h10C, 32'h100, 0, 0, 0);

        drive(2'd3, 0, 32'h0, 32'h200, 0, 0, 0);
        step("jr_c", 32'h200, 32'h104, 1, 0, 0);
        drive(2'd0, 0, 32'h0, 32'h0, 0, 1, 0);
        step("align_c", 32'h200, 32'h200, 0, 0, 0);
        drive(2'd3, 0, 32'h0, 32'h1002, 0, 0, 0);
        e_epc0 = 32'h200; e_epc1 = 32'h200;
        step("misalign", EXC, EXC, 0, 1, 0);
        drive(2'd0, 0, 32'h0, 32'h0, 0, 0, 0);
        step("mis_clear", 32'h8000_0184, 32'h8000_0184, 0, 0, 0);

        drive(2'd2, 0, 32'h0000_0040, 32'h0, 0, 0, 0);
        step("jump_s", 32'h8000_0100, 32'h8000_0188, 1, 0, 0);
        drive(2'd2, 0, 32'h0000_0080, 32'h0, 0, 0, 0);
        step("violation", 32'h8000_0200, 32'h8000_0100, 0, 0, 1);
        drive(2'd0, 0, 32'h0, 32'h0, 0, 0, 0);
        step("viol_clear", 32'h8000_0204, 32'h8000_0104, 0, 0, 0);

        drive(2'd3, 0, 32'h0, 32'h300, 0, 0, 0);
        step("jr_d", 32'h300, 32'h8000_0108, 1, 0, 0);
        drive(2'd0, 0, 32'h0, 32'h0, 1, 1, 1);
        e_epc0 = 32'h300; e_epc1 = 32'h8000_0108;
        step("exc_stall", EXC, EXC, 0, 0, 0);
        drive(2'd0, 0, 32'h0, 32'h0, 0, 0, 0);
        step("after_exc", 32'h8000_0184, 32'h8000_0184, 0, 0, 0);

        drive(2'd2, 0, 32'h0, 32'h0, 0, 0, 0);
        step("jump_m", 32'h8000_0000, 32'h8000_0188, 1, 0, 0);
        drive(2'd3, 0, 32'h0, 32'h3, 0, 0, 0);
        e_epc0 = 32'h8000_0000; e_epc1 = 32'h8000_0188;
        step("mis_slot", EXC, EXC, 0, 1, 0);
        drive(2'd0, 0, 32'h0, 32'h0, 0, 0, 0);
        step("mis_s_clr", 32'h8000_0184, 32'h8000_0184, 0, 0, 0);

        drive(2'd3, 0, 32'h0, 32'h500, 0, 0, 0);
        step("jr_e", 32'h500, 32'h8000_0188, 1, 0, 0);
        rst_n = 1'b0;
        drive(2'd0, 0, 32'h0, 32'h0, 0, 0, 0);
        e_epc0 = 32'h0; e_epc1 = 32'h0;
        expect_out("rst_mid", 32'h0, 32'h0, 0, 0, 0);
        #2;
        check_pop();
        rst_n = 1'b1;
        step("rst_run1", 32'h4, 32'h4, 0, 0, 0);
        step("rst_run2", 32'h8, 32'h8, 0, 0, 0);

        drive(2'd3, 0, 32'h0, 32'hFFFF_FFFC, 0, 0, 0);
        step("jr_wrap", 32'hFFFF_FFFC, 32'hC, 1, 0, 0);
        drive(2'd0, 0, 32'h0, 32'h0, 0, 1, 0);
        step("align_w", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 0, 0);
        drive(2'd0, 0, 32'h0, 32'h0, 0, 0, 0);
        step("wrap", 32'h0, 32'h0, 0, 0, 0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
